// File: rtl/simple_cpu_hs.sv
// simple_cpu_hs: multicycle register/memory core fed one instruction at a time by a sequencer.
// Latency: ALU/NOP instructions write back 3 edges after the accept edge; LOAD/STORE after 4 edges.
// Backpressure: instr_ready is high only in IDLE; instr is ignored while the core is busy.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   instr, instr_valid instruction word and its valid (sampled only when instr_ready)
//   instr_ready, busy  handshake ready / FSM not idle
//   done               one-cycle pulse after the WB state exits
//   zero_flag          last ALU result was zero
//   carry_flag         carry of last ADD or borrow of last SUB (0 for other ALU ops)
//   dbg_sel, dbg_data  combinational register file read port
//
// Instruction layout, MSB first: class[2] | X1 | X2 | X3 | ... | imm[DATA_WIDTH+3:4] | func[3:0]
module simple_cpu_hs #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int REG_BITS    = 2,
  parameter int INSTR_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   zero_flag,
  output logic                   carry_flag,
  input  logic [REG_BITS-1:0]    dbg_sel,
  output logic [DATA_WIDTH-1:0]  dbg_data
);

  localparam int NREGS = 1 << REG_BITS;
  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [1:0] CLS_NOP   = 2'b00;
  localparam logic [1:0] CLS_ALU   = 2'b01;
  localparam logic [1:0] CLS_LOAD  = 2'b10;
  localparam logic [1:0] CLS_STORE = 2'b11;

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_AND  = 4'd2;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_XOR  = 4'd4;
  localparam logic [3:0] F_SLTU = 4'd5;
  localparam logic [3:0] F_LDI  = 4'd6;

  logic [2:0]             state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0]  a_q, b_q, s_q;
  logic [DATA_WIDTH:0]    res_q;      // extra MSB holds ADD carry / SUB borrow
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   zero_q, carry_q, done_q;

  logic [DATA_WIDTH-1:0]  regfile [NREGS];
  logic [DATA_WIDTH-1:0]  mem     [DEPTH];

  // Decoded fields of the latched instruction
  logic [1:0]            cls;
  logic [REG_BITS-1:0]   x1, x2, x3;
  logic [DATA_WIDTH-1:0] imm;
  logic [3:0]            func;

  assign cls  = ir[INSTR_WIDTH-1 -: 2];
  assign x1   = ir[INSTR_WIDTH-3 -: REG_BITS];
  assign x2   = ir[INSTR_WIDTH-3-REG_BITS -: REG_BITS];
  assign x3   = ir[INSTR_WIDTH-3-2*REG_BITS -: REG_BITS];
  assign imm  = ir[DATA_WIDTH+3:4];
  assign func = ir[3:0];

  // ALU op with a defined function (7-15 behave as NOP: no write, no flag update)
  logic alu_wr;
  assign alu_wr = (cls == CLS_ALU) && (func <= F_LDI);

  logic [DATA_WIDTH:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (func)
      F_ADD:   alu_res = {1'b0, a_q} + {1'b0, b_q};
      F_SUB:   alu_res = {1'b0, a_q} - {1'b0, b_q};
      F_AND:   alu_res = {1'b0, a_q & b_q};
      F_OR:    alu_res = {1'b0, a_q | b_q};
      F_XOR:   alu_res = {1'b0, a_q ^ b_q};
      F_SLTU:  alu_res = (a_q < b_q) ? (DATA_WIDTH+1)'(1) : '0;
      F_LDI:   alu_res = {1'b0, imm};
      default: alu_res = '0;
    endcase
  end

  // Summing the operands already reduced to ADDR_BITS gives (X2+imm) mod depth,
  // so out-of-range addresses wrap without a wider adder.
  logic [ADDR_BITS-1:0] eff_addr;
  assign eff_addr = ADDR_BITS'(a_q) + ADDR_BITS'(imm);

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      res_q   <= '0;
      addr_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Operands captured here, so X1 aliasing X2/X3 reads the pre-write values
          a_q   <= regfile[x2];
          b_q   <= regfile[x3];
          s_q   <= regfile[x1];
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (cls == CLS_LOAD || cls == CLS_STORE) begin
            addr_q <= eff_addr;
            state  <= S_MEM;
          end else begin
            res_q <= alu_res;
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (cls == CLS_LOAD) begin
            res_q <= {1'b0, mem[addr_q]};
          end
          state <= S_WB;
        end
        S_WB: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
          if (alu_wr) begin
            zero_q  <= (res_q[DATA_WIDTH-1:0] == '0);
            carry_q <= (func == F_ADD || func == F_SUB) ? res_q[DATA_WIDTH] : 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register file: reset to its own index, written on the WB exit edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regfile[i] <= DATA_WIDTH'(i);
      end
    end else if (state == S_WB && (alu_wr || cls == CLS_LOAD)) begin
      regfile[x1] <= res_q[DATA_WIDTH-1:0];
    end
  end

  // Data memory: cleared on reset, STORE writes on the MEM edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == S_MEM && cls == CLS_STORE) begin
      mem[addr_q] <= s_q;
    end
  end

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign zero_flag   = zero_q;
  assign carry_flag  = carry_q;
  assign dbg_data    = regfile[dbg_sel];

endmodule

// File: tb/tb_simple_cpu_hs.sv
module tb_simple_cpu_hs;

  localparam logic [1:0] C_NOP = 2'b00, C_ALU = 2'b01, C_LD = 2'b10, C_ST = 2'b11;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLTU = 4'd5, LDI = 4'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] instr;
  logic        instr_valid;
  logic        instr_ready, busy, done, zero_flag, carry_flag;
  logic [1:0]  dbg_sel, mon_sel, stim_sel;
  logic        use_stim;
  logic [7:0]  dbg_data;

  assign dbg_sel = use_stim ? stim_sel : mon_sel;

  simple_cpu_hs dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int         id;
    bit         chk;    // check destination register value
    logic [1:0] rd;
    logic [7:0] val;
    bit         z;
    bit         c;
    int         lat;    // edges from accept edge to edge that raises done
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int accept_edge = 0;
  int last_done_edge = 0;

  localparam logic [19:0] GARBAGE = {C_ALU, 2'd0, 2'd0, 2'd0, 8'hEE, LDI};

  function automatic logic [19:0] enc(input logic [1:0] c, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] d,
                                      input logic [7:0] imm, input logic [3:0] fn);
    return {c, a, b, d, imm, fn};
  endfunction

  function automatic exp_t mk(input int id, input bit chk, input logic [1:0] rd,
                              input logic [7:0] val, input bit z, input bit c,
                              input int lat);
    exp_t e;
    e.id = id; e.chk = chk; e.rd = rd; e.val = val; e.z = z; e.c = c; e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard: compares each done pulse against the oldest expectation
  initial begin : monitor
    exp_t e;
    bit   d;
    bit   prev_done;
    int   lat;
    prev_done = 1'b0;
    mon_sel   = '0;
    forever begin
      @(negedge clk);
      d = done;
      if (d) begin
        chk("done_one_cycle", 32'(prev_done), 0);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done at edge %0d, expected none", edge_cnt);
        end else begin
          e   = exp_q.pop_front();
          lat = edge_cnt - accept_edge;
          chk($sformatf("vec%0d latency", e.id), lat, e.lat);
          chk($sformatf("vec%0d zero", e.id), 32'(zero_flag), 32'(e.z));
          chk($sformatf("vec%0d carry", e.id), 32'(carry_flag), 32'(e.c));
          chk($sformatf("vec%0d ready", e.id), 32'(instr_ready), 1);
          chk($sformatf("vec%0d busy", e.id), 32'(busy), 0);
          if (e.chk) begin
            mon_sel = e.rd;
            #1;
            chk($sformatf("vec%0d r%0d", e.id, e.rd), 32'(dbg_data), 32'(e.val));
          end
          last_done_edge = edge_cnt;
        end
      end
      prev_done = d;
      // Accept happens on the next rising edge
      if (rst && instr_valid && instr_ready) accept_edge = edge_cnt + 1;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " ready"}, 32'(instr_ready), 1);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " zero"}, 32'(zero_flag), 0);
    chk({tag, " carry"}, 32'(carry_flag), 0);
    use_stim = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stim_sel = 2'(i);
      #1;
      chk($sformatf("%s r%0d", tag, i), 32'(dbg_data), i);
    end
    use_stim = 1'b0;
  endtask

  // Present a word, wait for the accept edge; with hold, valid stays high and the
  // word is replaced by garbage that must never execute.
  task automatic send(input logic [19:0] w, input bit push, input exp_t e, input bit hold);
    int n;
    n = 0;
    instr = w;
    instr_valid = 1'b1;
    if (push) exp_q.push_back(e);
    while (!instr_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: instr_ready stayed 0 for %0d cycles, expected 1", n);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    instr = GARBAGE;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && instr_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL idle_timeout: %0d expectations pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  exp_t none;

  initial begin : stim
    int t0;
    none = mk(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; instr_valid = 1'b0; instr = '0; use_stim = 1'b0; stim_sel = '0;

    // 1: reset state and a first ADD
    do_reset();
    check_reset_state("t1");
    send(enc(C_ALU, 0, 1, 3, 0, ADD), 1, mk(1, 1, 0, 4, 0, 0, 3), 0);
    wait_idle();

    // 2: SUB chain, LDI and ADD overflow, SUB borrow
    send(enc(C_ALU, 3, 0, 2, 0, SUB), 1, mk(21, 1, 3, 2, 0, 0, 3), 0);
    send(enc(C_ALU, 1, 2, 3, 0, SUB), 1, mk(22, 1, 1, 0, 1, 0, 3), 0);
    send(enc(C_ALU, 0, 2, 1, 0, SUB), 1, mk(23, 1, 0, 2, 0, 0, 3), 0);
    send(enc(C_ALU, 1, 0, 0, 200, LDI), 1, mk(24, 1, 1, 200, 0, 0, 3), 0);
    send(enc(C_ALU, 0, 1, 1, 0, ADD), 1, mk(25, 1, 0, 144, 0, 1, 3), 0);
    send(enc(C_ALU, 2, 0, 1, 0, SUB), 1, mk(26, 1, 2, 200, 0, 1, 3), 0);
    wait_idle();

    // 3: STORE/LOAD leave flags (carry=1 from 0-1) untouched
    do_reset();
    send(enc(C_ALU, 0, 0, 1, 0, SUB), 1, mk(31, 1, 0, 255, 0, 1, 3), 0);
    send(enc(C_ST, 1, 2, 0, 15, 0), 1, mk(32, 0, 0, 0, 0, 1, 4), 0);
    send(enc(C_LD, 3, 2, 0, 15, 0), 1, mk(33, 1, 3, 1, 0, 1, 4), 0);
    send(enc(C_LD, 1, 2, 0, 14, 0), 1, mk(34, 1, 1, 0, 0, 1, 4), 0);
    wait_idle();

    // 4: address wrap 3+30 -> 1
    do_reset();
    send(enc(C_ST, 2, 3, 0, 30, 0), 1, mk(41, 0, 0, 0, 0, 0, 4), 0);
    send(enc(C_LD, 0, 0, 0, 1, 0), 1, mk(42, 1, 0, 2, 0, 0, 4), 0);
    wait_idle();

    // 5: back-to-back with valid held and instr changing while busy
    do_reset();
    t0 = edge_cnt;
    send(enc(C_ALU, 0, 1, 2, 0, ADD), 1, mk(51, 1, 0, 3, 0, 0, 3), 1);
    send(enc(C_ALU, 3, 3, 1, 0, XOR_), 1, mk(52, 1, 3, 2, 0, 0, 3), 1);
    send(enc(C_ALU, 0, 1, 2, 0, SLTU), 1, mk(53, 1, 0, 1, 0, 0, 3), 0);
    wait_idle();
    chk("t5 b2b_edges", last_done_edge - t0, 12);
    send(enc(C_ALU, 3, 2, 1, 0, AND_), 1, mk(54, 1, 3, 0, 1, 0, 3), 0);
    send(enc(C_ALU, 3, 2, 1, 0, OR_), 1, mk(55, 1, 3, 3, 0, 0, 3), 0);
    send(enc(C_ALU, 1, 3, 2, 0, SLTU), 1, mk(56, 1, 1, 0, 1, 0, 3), 0);
    send(enc(C_ALU, 2, 0, 1, 0, 4'd9), 1, mk(57, 1, 2, 2, 1, 0, 3), 0);
    send(enc(C_NOP, 2, 0, 1, 8'h55, 0), 1, mk(58, 1, 2, 2, 1, 0, 3), 0);
    send(enc(C_ALU, 2, 3, 3, 0, ADD), 1, mk(59, 1, 2, 6, 0, 0, 3), 0);
    send(enc(C_ALU, 2, 0, 0, 0, LDI), 1, mk(60, 1, 2, 0, 1, 0, 3), 0);
    wait_idle();

    // 6: reset during EXEC aborts the ADD and clears memory
    send(enc(C_ST, 3, 3, 0, 0, 0), 1, mk(61, 0, 0, 0, 1, 0, 4), 0);
    wait_idle();
    send(enc(C_ALU, 0, 1, 3, 0, ADD), 0, none, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_state("t6");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    begin
      bit saw;
      saw = 1'b0;
      repeat (6) begin
        @(posedge clk); #1;
        saw = saw | done;
      end
      chk("t6 no_done_after_abort", 32'(saw), 0);
    end
    send(enc(C_LD, 1, 3, 0, 0, 0), 1, mk(62, 1, 1, 0, 0, 0, 4), 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
